// File: rtl/led_pattern_driver.sv
// led_pattern_driver: debounces a raw push-button into a press pulse that
// cycles the LED mode (OFF, ON, ALT blink, FADE PWM) and drives two LEDs.
module led_pattern_driver #(
  parameter int TICK_DIV   = 6000000,
  parameter int DEB_CYCLES = 120000,
  parameter int PWM_BITS   = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn,
  output logic       led0,
  output logic       led1,
  output logic [1:0] mode
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int DEB_W = $clog2(DEB_CYCLES);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DEB_W-1:0]    DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  localparam logic [1:0] M_OFF  = 2'd0;
  localparam logic [1:0] M_ON   = 2'd1;
  localparam logic [1:0] M_ALT  = 2'd2;
  localparam logic [1:0] M_FADE = 2'd3;

  logic                sync1_q, sync2_q;
  logic                stable_q, stable_d, stable_prev_q;
  logic [DEB_W-1:0]    deb_cnt_q, deb_cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic                tick, press;
  logic [1:0]          mode_q, mode_d;
  logic                phase_q, phase_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic                dir_q, dir_d;   // 0 = duty counting up, 1 = down
  logic                led0_q, led0_d, led1_q, led1_d;

  // Debounce: accept a new level only after DEB_CYCLES consecutive mismatches.
  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q == stable_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_LAST) begin
      stable_d  = sync2_q;
      deb_cnt_d = '0;
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
  end

  // Two-flop synchroniser, debounced level and its one-cycle history.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      deb_cnt_q     <= '0;
    end else begin
      sync1_q       <= btn;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      deb_cnt_q     <= deb_cnt_d;
    end
  end

  // Press fires in the cycle after the debounced level rises; release is ignored.
  assign press = stable_q & ~stable_prev_q;

  // Free-running prescaler; tick marks the cycle whose edge wraps it to 0.
  assign tick  = (div_q == DIV_LAST);
  assign div_d = tick ? '0 : div_q + 1'b1;

  // Prescaler register, independent of the mode.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) div_q <= '0;
    else       div_q <= div_d;
  end

  // Mode sequencing and per-mode step state; a mode change overrides a tick.
  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    duty_d  = duty_q;
    dir_d   = dir_q;
    pwm_d   = pwm_q;
    if (press) begin
      mode_d  = mode_q + 2'd1;
      phase_d = 1'b0;
      duty_d  = '0;
      dir_d   = 1'b0;
      pwm_d   = '0;
    end else begin
      if (mode_q == M_ALT && tick) phase_d = ~phase_q;
      if (mode_q == M_FADE) begin
        pwm_d = pwm_q + 1'b1;
        if (tick) begin
          // Duty bounces off both ends instead of wrapping.
          if (!dir_q) begin
            if (duty_q == DUTY_MAX) begin
              dir_d  = 1'b1;
              duty_d = duty_q - 1'b1;
            end else begin
              duty_d = duty_q + 1'b1;
            end
          end else begin
            if (duty_q == '0) begin
              dir_d  = 1'b0;
              duty_d = duty_q + 1'b1;
            end else begin
              duty_d = duty_q - 1'b1;
            end
          end
        end
      end
    end
  end

  // Mode FSM and pattern state registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q  <= M_OFF;
      phase_q <= 1'b0;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      pwm_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      phase_q <= phase_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      pwm_q   <= pwm_d;
    end
  end

  // LED pattern decode from the current mode and step state.
  always_comb begin
    led0_d = 1'b0;
    led1_d = 1'b0;
    case (mode_q)
      M_OFF: begin
        led0_d = 1'b0;
        led1_d = 1'b0;
      end
      M_ON: begin
        led0_d = 1'b1;
        led1_d = 1'b1;
      end
      M_ALT: begin
        led0_d = phase_q;
        led1_d = ~phase_q;
      end
      default: begin
        led0_d = (pwm_q < duty_q);
        led1_d = (pwm_q < (DUTY_MAX - duty_q));
      end
    endcase
  end

  // Registered LED drive so the pins are glitch-free.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led0_q <= 1'b0;
      led1_q <= 1'b0;
    end else begin
      led0_q <= led0_d;
      led1_q <= led1_d;
    end
  end

  assign led0 = led0_q;
  assign led1 = led1_q;
  assign mode = mode_q;

endmodule
